// File: rtl/cg_iteration_sequencer.sv
// Iteration sequencer for the conjugate-gradient ALU datapath.
// Steps SAVE_R, MXV, VXV, ALPHA, UPDATE and CHECK once per iteration.
module cg_iteration_sequencer #(
  parameter int number_of_clusters        = 40,
  parameter int memory_read_address_width = 20,
  parameter int iter_width                = 16,
  parameter int timeout_cycles            = 65535
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 go,
  input  logic                                 abort,
  input  logic [iter_width-1:0]                max_iterations,
  input  logic                                 converged,
  input  logic                                 mXv1_finish,
  input  logic                                 vXv1_finish,
  input  logic                                 finish_alpha,
  input  logic                                 finish_iteration,
  output logic                                 reset_mXv1,
  output logic                                 reset_vXv1,
  output logic                                 reset_iteration,
  output logic                                 memoryRprev_we,
  output logic [memory_read_address_width-1:0] memoryR_read_address,
  output logic [iter_width-1:0]                iteration_count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 timeout_err
);

  typedef enum logic [2:0] {
    IDLE, SAVE_R, MXV, VXV, ALPHA, UPDATE, CHECK, DONE
  } state_t;

  localparam int WW = $clog2(timeout_cycles + 1);
  localparam logic [memory_read_address_width-1:0] ALAST =
    memory_read_address_width'(number_of_clusters - 1);
  localparam logic [WW-1:0] WLAST = WW'(timeout_cycles - 1);
  localparam logic [iter_width-1:0] CMAX = '1;

  state_t                state;
  logic [iter_width-1:0] lim;
  logic [WW-1:0]         wcnt;
  logic [iter_width-1:0] next_count;
  logic                  expired;

  assign next_count = (iteration_count == CMAX) ?
                      iteration_count : iteration_count + 1'b1;
  assign expired    = (wcnt == WLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      lim                  <= '0;
      wcnt                 <= '0;
      reset_mXv1           <= 1'b0;
      reset_vXv1           <= 1'b0;
      reset_iteration      <= 1'b0;
      memoryRprev_we       <= 1'b0;
      memoryR_read_address <= '0;
      iteration_count      <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      timeout_err          <= 1'b0;
    end else begin
      reset_mXv1      <= 1'b0;
      reset_vXv1      <= 1'b0;
      reset_iteration <= 1'b0;
      done            <= 1'b0;
      if (state != IDLE && abort) begin
        state                <= IDLE;
        memoryRprev_we       <= 1'b0;
        memoryR_read_address <= '0;
        busy                 <= 1'b0;
        wcnt                 <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (go) begin
              lim             <= max_iterations;
              iteration_count <= '0;
              timeout_err     <= 1'b0;
              busy            <= 1'b1;
              if (max_iterations == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state                <= SAVE_R;
                memoryRprev_we       <= 1'b1;
                memoryR_read_address <= '0;
              end
            end
          end
          SAVE_R: begin
            if (memoryR_read_address == ALAST) begin
              state                <= MXV;
              memoryRprev_we       <= 1'b0;
              memoryR_read_address <= '0;
              reset_mXv1           <= 1'b1;
              wcnt                 <= '0;
            end else begin
              memoryR_read_address <= memoryR_read_address + 1'b1;
            end
          end
          // The strobe register doubles as the first-cycle mask.
          MXV: begin
            wcnt <= wcnt + 1'b1;
            if (!reset_mXv1 && mXv1_finish) begin
              state      <= VXV;
              reset_vXv1 <= 1'b1;
              wcnt       <= '0;
            end else if (expired) begin
              state       <= IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          VXV: begin
            wcnt <= wcnt + 1'b1;
            if (!reset_vXv1 && vXv1_finish) begin
              state           <= ALPHA;
              reset_iteration <= 1'b1;
              wcnt            <= '0;
            end else if (expired) begin
              state       <= IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          ALPHA: begin
            wcnt <= wcnt + 1'b1;
            if (!reset_iteration && finish_alpha) begin
              state <= UPDATE;
              wcnt  <= '0;
            end else if (expired) begin
              state       <= IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          UPDATE: begin
            wcnt <= wcnt + 1'b1;
            if (finish_iteration) begin
              state <= CHECK;
              wcnt  <= '0;
            end else if (expired) begin
              state       <= IDLE;
              busy        <= 1'b0;
              timeout_err <= 1'b1;
            end
          end
          CHECK: begin
            iteration_count <= next_count;
            if (next_count == lim || converged) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state                <= SAVE_R;
              memoryRprev_we       <= 1'b1;
              memoryR_read_address <= '0;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Randomized self-checking bench for cg_iteration_sequencer.
// A transaction-level model predicts strobe order, copy length and count.
module tb_cg_iteration_sequencer;

  localparam int NC = 40;
  localparam int AW = 20;
  localparam int IW = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] max_iterations = '0;
  logic          converged = 1'b0;
  logic          mXv1_finish = 1'b0;
  logic          vXv1_finish = 1'b0;
  logic          finish_alpha = 1'b0;
  logic          finish_iteration = 1'b0;
  logic          reset_mXv1;
  logic          reset_vXv1;
  logic          reset_iteration;
  logic          memoryRprev_we;
  logic [AW-1:0] memoryR_read_address;
  logic [IW-1:0] iteration_count;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  cg_iteration_sequencer #(
    .number_of_clusters(NC),
    .memory_read_address_width(AW),
    .iter_width(IW),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .abort(abort),
    .max_iterations(max_iterations),
    .converged(converged),
    .mXv1_finish(mXv1_finish),
    .vXv1_finish(vXv1_finish),
    .finish_alpha(finish_alpha),
    .finish_iteration(finish_iteration),
    .reset_mXv1(reset_mXv1),
    .reset_vXv1(reset_vXv1),
    .reset_iteration(reset_iteration),
    .memoryRprev_we(memoryRprev_we),
    .memoryR_read_address(memoryR_read_address),
    .iteration_count(iteration_count),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {reset_mXv1, reset_vXv1, reset_iteration,
            memoryRprev_we, busy, done, timeout_err};
  endfunction

  function automatic logic sel(input int which);
    case (which)
      0: return reset_mXv1;
      1: return reset_vXv1;
      2: return reset_iteration;
      default: return memoryRprev_we && memoryR_read_address == 17;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget,
                          input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (sel(which)) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s wait: event not seen within %0d cycles",
               name, budget);
    end
  endtask

  task automatic start(input int lim);
    max_iterations = IW'(lim);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic run_solve(input int lim, input int conv,
                           input int dmin, input int dmax,
                           input string name);
    int iters, we_cnt, addr_err, onehot_err, busy_err;
    int done_cnt, pend, cd, fin_it, exp_addr, cyc;
    logic prev_we, seen_done;
    string slog, exp_log;
    iters = (conv != 0 && conv < lim) ? conv : lim;
    exp_log = "";
    for (int i = 0; i < iters; i++) exp_log = {exp_log, "MVI"};
    slog = "";
    we_cnt = 0; addr_err = 0; onehot_err = 0; busy_err = 0;
    done_cnt = 0; pend = 0; cd = 0; fin_it = 0; exp_addr = 0;
    cyc = 0; prev_we = 1'b0; seen_done = 1'b0;
    start(lim);
    while (!seen_done && cyc < 3000) begin
      if ($countones({reset_mXv1, reset_vXv1, reset_iteration,
                      memoryRprev_we}) > 1) onehot_err++;
      if (!busy) busy_err++;
      if (memoryRprev_we) begin
        if (memoryR_read_address != AW'(exp_addr)) addr_err++;
        exp_addr = (exp_addr + 1) % NC;
        we_cnt++;
      end else begin
        if (memoryR_read_address != '0) addr_err++;
        if (prev_we && exp_addr != 0) addr_err++;
      end
      prev_we = memoryRprev_we;
      if (done) begin
        seen_done = 1'b1;
        done_cnt++;
      end
      mXv1_finish = 1'b0;
      vXv1_finish = 1'b0;
      finish_alpha = 1'b0;
      finish_iteration = 1'b0;
      if (reset_mXv1) begin
        slog = {slog, "M"}; pend = 1;
        cd = int'($urandom_range(dmax, dmin));
      end else if (reset_vXv1) begin
        slog = {slog, "V"}; pend = 2;
        cd = int'($urandom_range(dmax, dmin));
      end else if (reset_iteration) begin
        slog = {slog, "I"}; pend = 3;
        cd = int'($urandom_range(dmax, dmin));
      end else if (pend != 0) begin
        cd--;
        if (cd == 0) begin
          case (pend)
            1: begin mXv1_finish = 1'b1; pend = 0; end
            2: begin vXv1_finish = 1'b1; pend = 0; end
            3: begin
              finish_alpha = 1'b1; pend = 4;
              cd = int'($urandom_range(dmax, dmin));
            end
            default: begin
              finish_iteration = 1'b1; fin_it++; pend = 0;
            end
          endcase
        end
      end
      converged = (conv != 0 && fin_it >= conv);
      @(negedge clk);
      cyc++;
    end
    mXv1_finish = 1'b0;
    vXv1_finish = 1'b0;
    finish_alpha = 1'b0;
    finish_iteration = 1'b0;
    converged = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done) done_cnt++;
      if (outs() != 7'b0) busy_err++;
      @(negedge clk);
    end
    checks++;
    if (slog != exp_log) begin
      errors++;
      $display("FAIL %s strobe order: got '%s' expected '%s'",
               name, slog, exp_log);
    end
    checks++;
    if (we_cnt !== NC * iters) begin
      errors++;
      $display("FAIL %s we cycles: got %0d expected %0d",
               name, we_cnt, NC * iters);
    end
    checks++;
    if (addr_err !== 0) begin
      errors++;
      $display("FAIL %s addresses: got %0d bad expected 0", name, addr_err);
    end
    checks++;
    if (onehot_err !== 0) begin
      errors++;
      $display("FAIL %s exclusive strobes: got %0d overlaps expected 0",
               name, onehot_err);
    end
    checks++;
    if (busy_err !== 0) begin
      errors++;
      $display("FAIL %s busy: got %0d bad cycles expected 0",
               name, busy_err);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (iteration_count !== IW'(iters)) begin
      errors++;
      $display("FAIL %s iteration_count: got %0d expected %0d",
               name, iteration_count, iters);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset outputs: got %b expected 0000000", outs());
    end
    checks++;
    if (memoryR_read_address !== '0 || iteration_count !== '0) begin
      errors++;
      $display("FAIL reset counters: got addr %0d count %0d expected 0 0",
               memoryR_read_address, iteration_count);
    end
  endtask

  task automatic test_two_iterations();
    run_solve(2, 0, 5, 5, "two_iter");
  endtask

  task automatic test_converged();
    run_solve(10, 1, 5, 5, "converged");
  endtask

  task automatic test_random();
    int lim, conv;
    for (int k = 0; k < 4; k++) begin
      lim = int'($urandom_range(4, 1));
      conv = int'($urandom_range(lim, 0));
      run_solve(lim, conv, 1, 8, $sformatf("random%0d", k));
    end
  endtask

  task automatic test_zero_iterations();
    start(0);
    checks++;
    if (outs() !== 7'b0000110 || iteration_count !== '0) begin
      errors++;
      $display("FAIL zero first cycle: got %b count %0d expected 0000110 0",
               outs(), iteration_count);
    end
    @(negedge clk);
    checks++;
    if (outs() !== 7'b0 || iteration_count !== '0) begin
      errors++;
      $display("FAIL zero after: got %b count %0d expected 0000000 0",
               outs(), iteration_count);
    end
  endtask

  task automatic test_stale_finish();
    mXv1_finish = 1'b1;
    start(1);
    wait_sig(0, 200, "stale mxv strobe");
    @(negedge clk);
    checks++;
    if (reset_vXv1 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stale masked: got vxv %b busy %b expected 0 1",
               reset_vXv1, busy);
    end
    @(negedge clk);
    checks++;
    if (reset_vXv1 !== 1'b1) begin
      errors++;
      $display("FAIL stale advance: got vxv %b expected 1", reset_vXv1);
    end
    mXv1_finish = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL stale abort: got %b expected 0000000", outs());
    end
  endtask

  task automatic test_timeout();
    int first;
    logic saw_done;
    first = 0;
    saw_done = 1'b0;
    mXv1_finish = 1'b1;
    start(1);
    wait_sig(1, 200, "timeout vxv strobe");
    mXv1_finish = 1'b0;
    for (int k = 1; k <= TO + 10 && first == 0; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (timeout_err) first = k;
    end
    checks++;
    if (first !== TO) begin
      errors++;
      $display("FAIL timeout latency: got %0d expected %0d", first, TO);
    end
    checks++;
    if (outs() !== 7'b0000001 || saw_done) begin
      errors++;
      $display("FAIL timeout state: got %b done_seen %b expected 0000001 0",
               outs(), saw_done);
    end
    start(0);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout clear: got %b expected 0", timeout_err);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic bad;
    bad = 1'b0;
    start(3);
    wait_sig(3, 100, "abort addr17");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (memoryRprev_we !== 1'b0 || memoryR_read_address !== '0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: got we %b addr %0d busy %b done %b expected 0 0 0 0",
               memoryRprev_we, memoryR_read_address, busy, done);
    end
    for (int i = 0; i < 5; i++) begin
      if (outs() != 7'b0) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0 || iteration_count !== '0) begin
      errors++;
      $display("FAIL abort idle: got activity %b count %0d expected 0 0",
               bad, iteration_count);
    end
  endtask

  task automatic test_reset_mid();
    mXv1_finish = 1'b1;
    vXv1_finish = 1'b1;
    start(2);
    wait_sig(2, 300, "reset_mid alpha");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mXv1_finish = 1'b0;
    vXv1_finish = 1'b0;
    checks++;
    if (outs() !== 7'b0 || memoryR_read_address !== '0 ||
        iteration_count !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %b addr %0d count %0d expected 0 0 0",
               outs(), memoryR_read_address, iteration_count);
    end
    run_solve(1, 0, 1, 4, "after_reset");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_two_iterations();
    test_converged();
    test_random();
    test_zero_iterations();
    test_stale_finish();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
